// File: rtl/mat_add_writeback_if.sv
// Memory write port of mat_add_writeback.
// Write request holds address/data stable until mem_ready.
interface mat_add_writeback_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_write;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    output mem_write,
    output mem_addr,
    output mem_data,
    input  mem_ready
  );

  modport slave (
    input  mem_write,
    input  mem_addr,
    input  mem_data,
    output mem_ready
  );
endinterface

// File: rtl/mat_add_writeback.sv
// Collects fixed-latency adder results into a small FIFO and
// writes them to consecutive addresses from a latched base.
module mat_add_writeback #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 6,
  parameter int LATENCY    = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] res_base,
  input  logic [DIM_WIDTH-1:0]  dim1,
  input  logic [DIM_WIDTH-1:0]  dim2,
  input  logic                  issue,
  output logic                  issue_ready,
  input  logic [DATA_WIDTH-1:0] dataC,
  mat_add_writeback_if.master   mem,
  output logic                  busy,
  output logic                  done
);
  localparam int CNT_W = 2 * DIM_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = PTR_W + 1;
  localparam int IF_W  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_W-1:0]      total;
  logic [CNT_W-1:0]      issued_count;
  logic [CNT_W-1:0]      write_count;
  logic [IF_W-1:0]       inflight_count;
  logic [LATENCY-1:0]    vld;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [FC_W-1:0]       fifo_count;

  logic             accept;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic             launch;
  logic             last_write;
  logic [CNT_W-1:0] prod;
  logic [31:0]      occ;

  assign prod   = CNT_W'(dim1) * CNT_W'(dim2);
  assign launch = (state == IDLE) && start;
  assign occ    = 32'(fifo_count) + 32'(inflight_count);

  // Credit: in-flight results always have a FIFO slot waiting.
  assign issue_ready = (state == RUN)
                    && (issued_count < total)
                    && (occ < 32'(FIFO_DEPTH));

  assign accept  = issue && issue_ready;
  assign push    = vld[LATENCY-1];
  assign pop     = mem.mem_write && mem.mem_ready;
  assign push_ok = push
                && ((fifo_count != FC_W'(FIFO_DEPTH)) || pop);

  assign last_write = pop && (write_count == total - CNT_W'(1));

  assign mem.mem_write = (fifo_count != '0);
  assign mem.mem_data  = fifo_mem[rd_ptr];
  assign mem.mem_addr  = base_q + ADDR_WIDTH'(write_count);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (prod == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (last_write) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base_q         <= '0;
      total          <= '0;
      issued_count   <= '0;
      write_count    <= '0;
      inflight_count <= '0;
      vld            <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fifo_count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (launch) begin
        base_q         <= res_base;
        total          <= prod;
        issued_count   <= '0;
        write_count    <= '0;
        inflight_count <= '0;
      end else begin
        if (accept) issued_count <= issued_count + CNT_W'(1);
        if (pop)    write_count  <= write_count + CNT_W'(1);
        inflight_count <= inflight_count
                        + IF_W'(accept)
                        - IF_W'(push);
      end
      vld <= {vld[LATENCY-2:0], accept};
      if (push_ok) begin
        fifo_mem[wr_ptr] <= dataC;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count
                  + FC_W'(push_ok)
                  - FC_W'(pop);
    end
  end
endmodule

// File: tb/tb_mat_add_writeback.sv
// Directed bench for mat_add_writeback with a fixed-latency
// adder stand-in and a write logger.
module tb_mat_add_writeback;
  localparam int LAT = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] res_base = '0;
  logic [5:0]  dim1 = '0;
  logic [5:0]  dim2 = '0;
  logic        issue = 1'b0;
  logic        issue_ready;
  logic [31:0] dataC = '0;
  logic        busy;
  logic        done;

  mat_add_writeback_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) mem_bus ();

  mat_add_writeback dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .res_base    (res_base),
    .dim1        (dim1),
    .dim2        (dim2),
    .issue       (issue),
    .issue_ready (issue_ready),
    .dataC       (dataC),
    .mem         (mem_bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  logic [31:0] sched [int];
  logic [31:0] dval;
  logic [11:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          iss_cnt, first_iss, first_wr, last_wr;
  int          done_cnt, done_cyc, busy_cnt, rdy_late, job_total;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // adder stand-in: result appears LAT cycles after acceptance
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    dataC = sched.exists(cyc) ? sched[cyc] : 32'h0;
  end

  always @(negedge clock) begin
    if (issue && issue_ready) begin
      if (iss_cnt >= job_total) rdy_late++;
      sched[cyc + LAT] = dval;
      dval = dval + 32'd1;
      if (first_iss < 0) first_iss = cyc;
      iss_cnt++;
    end
    if (mem_bus.mem_write && first_wr < 0) first_wr = cyc;
    if (mem_bus.mem_write && mem_bus.mem_ready) begin
      wr_addr.push_back(mem_bus.mem_addr);
      wr_data.push_back(mem_bus.mem_data);
      last_wr = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log(input int tot, input logic [31:0] d0);
    wr_addr.delete();
    wr_data.delete();
    iss_cnt = 0; first_iss = -1; first_wr = -1; last_wr = -1;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; rdy_late = 0;
    job_total = tot;
    dval = d0;
  endtask

  task automatic start_job(input logic [11:0] b,
                           input logic [5:0] a, input logic [5:0] c);
    res_base = b; dim1 = a; dim2 = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_job(input bit rnd, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      issue = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_bus.mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    check("job_done", done, 1'b1);
    issue = 1'b0;
    mem_bus.mem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_writes(input string t, input int n,
                              input logic [11:0] b,
                              input logic [31:0] d0);
    check({t, "_count"}, wr_addr.size(), n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_addr%0d", t, k),
            k < wr_addr.size() ? wr_addr[k] : 12'hxxx, 12'(b + k));
      check($sformatf("%s_data%0d", t, k),
            k < wr_data.size() ? wr_data[k] : 32'hx, d0 + 32'(k));
    end
  endtask

  initial begin
    logic [11:0] wrap_addr [4];
    logic [11:0] snap_a;
    logic [31:0] snap_d;
    int          errs;
    int          n;

    wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    mem_bus.mem_ready = 1'b1;
    clear_log(0, 32'h0);
    tick();
    tick();
    check("rst_issue_ready", issue_ready, 1'b0);
    check("rst_mem_write", mem_bus.mem_write, 1'b0);
    check("rst_mem_addr", mem_bus.mem_addr, 12'h000);
    check("rst_mem_data", mem_bus.mem_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    tick();

    // 2x2, free-running
    clear_log(4, 32'hA100_0000);
    start_job(12'h100, 6'd2, 6'd2);
    check("t1_busy", busy, 1'b1);
    run_job(1'b0, 200);
    check_writes("t1", 4, 12'h100, 32'hA100_0000);
    check("t1_first_lat", first_wr - first_iss, 8);
    check("t1_done_lat", done_cyc - last_wr, 1);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_idle_busy", busy, 1'b0);

    // 3x3, memory stalled for 20 cycles
    clear_log(9, 32'hB200_0000);
    start_job(12'h200, 6'd3, 6'd3);
    snap_a = '0;
    snap_d = '0;
    for (int i = 0; i < 20; i++) begin
      issue = 1'b1;
      mem_bus.mem_ready = 1'b0;
      if (i == 12) begin
        snap_a = mem_bus.mem_addr;
        snap_d = mem_bus.mem_data;
      end
      tick();
    end
    check("t2_stall_issued", iss_cnt, 4);
    check("t2_stall_ready", issue_ready, 1'b0);
    check("t2_stall_writes", wr_addr.size(), 0);
    check("t2_stall_wr", mem_bus.mem_write, 1'b1);
    check("t2_hold_addr", mem_bus.mem_addr, snap_a);
    check("t2_hold_data", mem_bus.mem_data, snap_d);
    check("t2_head_addr", mem_bus.mem_addr, 12'h200);
    check("t2_head_data", mem_bus.mem_data, 32'hB200_0000);
    run_job(1'b0, 400);
    check_writes("t2", 9, 12'h200, 32'hB200_0000);
    check("t2_done_cnt", done_cnt, 1);

    // empty job
    clear_log(0, 32'hC300_0000);
    start_job(12'h123, 6'd0, 6'd5);
    check("t3_done", done, 1'b1);
    check("t3_busy", busy, 1'b1);
    tick();
    check("t3_done_off", done, 1'b0);
    check("t3_busy_off", busy, 1'b0);
    tick();
    check("t3_writes", wr_addr.size(), 0);
    check("t3_done_cnt", done_cnt, 1);
    check("t3_busy_cycles", busy_cnt, 1);

    // address wrap
    clear_log(4, 32'hD400_0000);
    start_job(12'hFFE, 6'd2, 6'd2);
    run_job(1'b0, 200);
    check("t4_count", wr_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t4_addr%0d", k),
            k < wr_addr.size() ? wr_addr[k] : 12'hxxx, wrap_addr[k]);
    end

    // reset mid-job, then a 1x1 job
    clear_log(16, 32'hE500_0000);
    start_job(12'h300, 6'd4, 6'd4);
    n = 0;
    while (iss_cnt < 6 && n < 200) begin
      issue = 1'b1;
      mem_bus.mem_ready = 1'b1;
      tick();
      n++;
    end
    check("t5_issued", iss_cnt, 6);
    issue = 1'b0;
    reset = 1'b1;
    tick();
    n = wr_addr.size();
    tick();
    check("t5_rst_ready", issue_ready, 1'b0);
    check("t5_rst_wr", mem_bus.mem_write, 1'b0);
    check("t5_rst_addr", mem_bus.mem_addr, 12'h000);
    check("t5_rst_data", mem_bus.mem_data, 32'h0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("t5_no_late_wr", wr_addr.size(), n);
    check("t5_no_done", done_cnt, 0);
    clear_log(1, 32'h0000_BEEF);
    start_job(12'h050, 6'd1, 6'd1);
    run_job(1'b0, 200);
    check_writes("t5b", 1, 12'h050, 32'h0000_BEEF);

    // 63x63 with random issue/ready
    clear_log(3969, 32'h0F00_0000);
    start_job(12'h000, 6'd63, 6'd63);
    run_job(1'b1, 60000);
    check("t6_count", wr_addr.size(), 3969);
    check("t6_issued", iss_cnt, 3969);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_ready_late", rdy_late, 0);
    errs = 0;
    for (int k = 0; k < wr_addr.size(); k++) begin
      if (wr_addr[k] !== 12'(k)) errs++;
      if (wr_data[k] !== 32'h0F00_0000 + 32'(k)) errs++;
    end
    check("t6_order_errs", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
